// File: rtl/ofifo_drain_ctrl.sv
// Drains num_rows rows from the show-ahead output FIFO into consecutive psum SRAM
// addresses, one row per CHECK/POP/HOLD pass. All control outputs are registered.
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11,
  parameter int rd_lat  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_w-1:0]        num_rows,
  input  logic [addr_w-1:0]        base_addr,
  input  logic                     ofifo_valid,
  input  logic                     ofifo_full,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_w-1:0]        sram_addr,
  output logic [col*psum_bw-1:0]   sram_din,
  output logic                     busy,
  output logic                     done,
  output logic [addr_w-1:0]        rows_done,
  output logic                     full_seen
);

  localparam int HOLD_W = (rd_lat > 1) ? $clog2(rd_lat) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(rd_lat - 1);

  typedef enum logic [2:0] {IDLE, CHECK, POP, HOLD, DONE} state_t;

  state_t              state;
  logic [addr_w-1:0]   num_q;
  logic [addr_w-1:0]   base_q;
  logic [HOLD_W-1:0]   hold_cnt;

  // The SRAM captures the FIFO head directly during the POP cycle.
  assign sram_din = ofifo_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ofifo_rd  <= 1'b0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rows_done <= '0;
      full_seen <= 1'b0;
      num_q     <= '0;
      base_q    <= '0;
      hold_cnt  <= '0;
    end else begin
      // busy is high exactly in the non-IDLE states, so it qualifies the sticky flag.
      if (busy && ofifo_full)
        full_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            rows_done <= '0;
            full_seen <= 1'b0;
            busy      <= 1'b1;
            if (num_rows != '0) begin
              num_q  <= num_rows;
              base_q <= base_addr;
              state  <= CHECK;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        CHECK: begin
          if (ofifo_valid) begin
            ofifo_rd  <= 1'b1;
            sram_cen  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_addr <= base_q + rows_done;
            state     <= POP;
          end
        end

        POP: begin
          ofifo_rd  <= 1'b0;
          sram_cen  <= 1'b1;
          sram_wen  <= 1'b1;
          rows_done <= rows_done + addr_w'(1);
          hold_cnt  <= '0;
          state     <= HOLD;
        end

        // The FIFO registers rd, so ofifo_valid is stale until the hold expires.
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (rows_done == num_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CHECK;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
